// File: rtl/alu_pipe_n.sv
// N-bit registered ALU with valid/ready on both sides, status flags and an
// iterative shift-add multiply (N+1 cycles). One operation in flight.
module alu_pipe_n #(
    parameter int N      = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operand1,
    input  logic [N-1:0] operand2,
    input  logic [2:0]   operation,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c,
    output logic         flag_v,
    output logic         err
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
    state_t state, state_nx;

    logic           out_free, accept, is_mul, load_out;
    logic [N:0]     sum, diff;
    logic [N-1:0]   b_neg, alu_res, ld_res;
    logic [SW-1:0]  shamt;
    logic           alu_c, alu_v, alu_err, ld_c, ld_v, ld_err;
    logic [2*N-1:0] mcand, acc;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;

    // The output slot is free when empty or being drained this very edge.
    assign out_free = !out_valid || out_ready;
    assign in_ready = reset && (state == IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (operation == 3'd7);

    assign sum   = {1'b0, operand1} + {1'b0, operand2};
    assign diff  = {1'b0, operand1} - {1'b0, operand2};
    assign b_neg = ~operand2 + N'(1);
    assign shamt = operand2[SW-1:0];

    // Single-cycle datapath; a shift by >= N falls out as zero naturally.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (operation)
            3'd0: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (operand1[N-1] == operand2[N-1]) && (sum[N-1] != operand1[N-1]);
            end
            3'd1: begin
                alu_res = diff[N-1:0];
                alu_c   = diff[N];
                alu_v   = (operand1[N-1] == b_neg[N-1]) && (diff[N-1] != operand1[N-1]);
            end
            3'd2:    alu_res = operand1 & operand2;
            3'd3:    alu_res = operand1 | operand2;
            3'd4:    alu_res = operand1 ^ operand2;
            3'd5:    alu_res = operand1 << shamt;
            3'd6:    alu_res = operand1 >> shamt;
            default: alu_err = (MUL_EN == 1'b0);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && is_mul) state_nx = MUL_BUSY;
            MUL_BUSY: if (cnt == CW'(1)) state_nx = MUL_DONE;
            MUL_DONE: if (out_free) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Source select for the output register: ALU on accept, product when done.
    always_comb begin
        load_out = 1'b0;
        ld_res   = alu_res;
        ld_c     = alu_c;
        ld_v     = alu_v;
        ld_err   = alu_err;
        if (accept && !is_mul) load_out = 1'b1;
        if (state == MUL_DONE && out_free) begin
            load_out = 1'b1;
            ld_res   = acc[N-1:0];
            ld_c     = |acc[2*N-1:N];
            ld_v     = 1'b0;
            ld_err   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            result    <= ld_res;
            flag_z    <= (ld_res == '0);
            flag_n    <= ld_res[N-1];
            flag_c    <= ld_c;
            flag_v    <= ld_v;
            err       <= ld_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Shift-add multiplier: one partial product per cycle, LSB of B first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            mcand  <= {{N{1'b0}}, operand1};
            mplier <= operand2;
            acc    <= '0;
            cnt    <= CW'(N);
        end else if (state == MUL_BUSY) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_alu_pipe_n.sv
// Bench for alu_pipe_n: directed timing/flag cases plus randomized traffic
// with a queue scoreboard fed from an arithmetic reference model.
module tb_alu_pipe_n;
    localparam int N  = 4;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [N-1:0] res;
        logic         z, n, c, v, e;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] operand1, operand2, result;
    logic [2:0]   operation;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    logic         in_valid0, in_ready0, out_valid0;
    logic [N-1:0] operand10, operand20, result0;
    logic [2:0]   operation0;
    logic         flag_z0, flag_n0, flag_c0, flag_v0, err0;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   rnd_on;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_pipe_n #(.N(N), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .operation(operation),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    alu_pipe_n #(.N(N), .MUL_EN(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .operand1(operand10), .operand2(operand20), .operation(operation0),
        .out_valid(out_valid0), .out_ready(1'b1), .result(result0),
        .flag_z(flag_z0), .flag_n(flag_n0), .flag_c(flag_c0), .flag_v(flag_v0), .err(err0)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input int op, input int a, input int b, input bit mul_en);
        int   m, h, r, nb, sh, p;
        exp_t e;
        m  = 1 << N;
        h  = m / 2;
        sh = b % (1 << SW);
        e  = '0;
        r  = 0;
        case (op)
            0: begin
                r   = a + b;
                e.c = (r >= m);
                r   = r % m;
                e.v = ((a >= h) == (b >= h)) && ((r >= h) != (a >= h));
            end
            1: begin
                r   = (a - b + m) % m;
                e.c = (a < b);
                nb  = (m - b) % m;
                e.v = ((a >= h) == (nb >= h)) && ((r >= h) != (a >= h));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (sh >= N) ? 0 : (a << sh) % m;
            6: r = (sh >= N) ? 0 : (a >> sh);
            default: begin
                if (mul_en) begin
                    p   = a * b;
                    r   = p % m;
                    e.c = (p >= m);
                end else begin
                    e.e = 1'b1;
                end
            end
        endcase
        e.res = r[N-1:0];
        e.z   = (r == 0);
        e.n   = (r >= h);
        return e;
    endfunction

    // Monitor: a transfer completes on the edge following a negedge with valid&&ready.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_flags", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < c && g < 1000);
    endtask

    // Present an op, hold until accepted, push the expectation; returns the accept cycle.
    task automatic issue(input int op, input int a, input int b, output int k);
        int n;
        in_valid  = 1'b1;
        operation = 3'(op);
        operand1  = N'(a);
        operand2  = N'(b);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            k = cyc;
        end else begin
            sb.push_back(model(op, a, b, 1'b1));
            @(posedge clk);
            #1;
            k = cyc;
        end
        in_valid = 1'b0;
        operand1 = N'($urandom);
        operand2 = N'($urandom);
        operation = 3'($urandom);
    endtask

    initial begin
        int k, g;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rnd_on = 1'b0;
        operand1 = '0; operand2 = '0; operation = '0;
        in_valid0 = 1'b0; operand10 = '0; operand20 = '0; operation0 = '0;

        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_result", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // ADD 7+9: zero with carry, visible right after the accept edge.
        issue(0, 7, 9, k);
        wait_to(k);
        check("add_lat", {31'd0, out_valid}, 32'd1);
        check("add_7_9", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, 4'h0, 5'b10100});
        step();
        issue(1, 3, 5, k);
        wait_to(k);
        check("sub_3_5", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, 4'hE, 5'b01100});
        step();
        issue(0, 7, 1, k);
        wait_to(k);
        check("add_7_1", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, 4'h8, 5'b01010});
        step();
        issue(5, 3, 2, k);
        wait_to(k);
        check("shl_3_2", {28'd0, result}, 32'hC);
        step();

        // MUL 5*3: absent N edges after accept, present after N+1.
        issue(7, 5, 3, k);
        wait_to(k + 1);
        check("mul_busy_ready", {31'd0, in_ready}, 32'd0);
        wait_to(k + N);
        check("mul_early", {31'd0, out_valid}, 32'd0);
        wait_to(k + N + 1);
        check("mul_lat", {31'd0, out_valid}, 32'd1);
        check("mul_5_3", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, 4'hF, 5'b01000});
        step();
        issue(7, 6, 6, k);
        wait_to(k + N + 1);
        check("mul_6_6", {23'd0, result, flag_z, flag_n, flag_c, flag_v, err}, {23'd0, 4'h4, 5'b00100});
        step(); step(); step();

        // Backpressure: ADD 2+2 held while out_ready=0, next op blocked.
        out_ready = 1'b0;
        issue(0, 2, 2, k);
        in_valid = 1'b1; operation = 3'd3; operand1 = 4'h1; operand2 = 4'h2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {26'd0, out_valid, result, in_ready}, {26'd0, 1'b1, 4'h4, 1'b0});
        end
        step();
        out_ready = 1'b1;
        issue(3, 1, 2, k);
        step(); step();

        // Reset two cycles into MUL 6*6: result must never appear.
        issue(7, 6, 6, k);
        wait_to(k + 2);
        reset = 1'b0;
        sb.delete();
        #1;
        check("midrst_clear", {30'd0, out_valid, in_ready}, 32'd0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rel", {30'd0, out_valid, in_ready}, 32'd1);
        wait_to(k + N + 4);
        check("midrst_stale", {31'd0, out_valid}, 32'd0);
        step();

        // MUL_EN=0 instance: op 7 is a one-cycle error returning zero.
        in_valid0 = 1'b1; operation0 = 3'd7; operand10 = 4'h5; operand20 = 4'h3;
        @(negedge clk);
        check("mul_off_ready", {31'd0, in_ready0}, 32'd1);
        step();
        in_valid0 = 1'b1; operation0 = 3'd0; operand10 = 4'h2; operand20 = 4'h3;
        @(negedge clk);
        check("mul_off", {22'd0, out_valid0, result0, flag_z0, flag_n0, flag_c0, flag_v0, err0},
              {22'd0, 1'b1, model(7, 5, 3, 1'b0)});
        step();
        in_valid0 = 1'b0;
        @(negedge clk);
        check("off_add", {22'd0, out_valid0, result0, flag_z0, flag_n0, flag_c0, flag_v0, err0},
              {22'd0, 1'b1, model(0, 2, 3, 1'b0)});
        step();

        // Randomized traffic with random downstream backpressure.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    step();
                    out_ready = ($urandom % 4) != 0;
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom % 4 == 0) step();
                    issue(int'($urandom % 8), int'($urandom % 16), int'($urandom % 16), k);
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 100) begin
            step();
            g++;
        end
        check("drain", {31'd0, out_valid}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
